// File: rtl/period_meter_pkg.sv
// Shared types and BCD helpers for the period meter.
package period_meter_pkg;

    localparam int unsigned BCD_W         = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'b00,
        MEASURE    = 2'b01,
        SATURATED  = 2'b10
    } state_t;

    // Next value of a BCD digit after +1; 9 wraps to 0.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] digit);
        logic [BCD_W-1:0] nxt;
        if (digit >= BCD_W'(BCD_MAX_DIGIT)) begin
            nxt = '0;
        end else begin
            nxt = digit + BCD_W'(1);
        end
        return nxt;
    endfunction

    // Carry out of a BCD digit when it is incremented.
    function automatic logic bcd_carry(input logic [BCD_W-1:0] digit, input logic inc);
        return inc && (digit == BCD_W'(BCD_MAX_DIGIT));
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the period counter: clear, increment, carry on 9.
module bcd_digit_counter
    import period_meter_pkg::*;
(
    input  logic             clk,
    input  logic             init,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry_c
);

    assign carry_c = bcd_carry(digit, inc);

    // Digit register; clear wins over increment.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= bcd_next(digit);
        end
    end

endmodule

// File: rtl/period_meter_bcd.sv
// Measures the period of sig_in in clk cycles and presents it as two BCD digits.
module period_meter_bcd
    import period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_BCD     = 99
) (
    input  logic clk,
    input  logic init,
    input  logic sig_in,
    output logic D_MSB,
    output logic C_MSB,
    output logic B_MSB,
    output logic A_MSB,
    output logic D_LSB,
    output logic C_LSB,
    output logic B_LSB,
    output logic A_LSB,
    output logic valid,
    output logic ovf
);

    localparam logic [BCD_W-1:0] SAT_TENS  = BCD_W'(MAX_BCD / 10);
    localparam logic [BCD_W-1:0] SAT_UNITS = BCD_W'(MAX_BCD % 10);
    localparam logic [BCD_W-1:0] THR_TENS  = BCD_W'((MAX_BCD - 1) / 10);
    localparam logic [BCD_W-1:0] THR_UNITS = BCD_W'((MAX_BCD - 1) % 10);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_c;

    state_t state_q;
    state_t state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   load_meas;
    logic   load_sat;

    logic [BCD_W-1:0] units;
    logic [BCD_W-1:0] tens;
    logic             units_carry_c;
    logic             tens_carry_c;
    logic             at_thr_c;
    logic [BCD_W-1:0] plus_units_c;
    logic [BCD_W-1:0] plus_tens_c;

    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] units_q;

    // Synchroniser chain plus edge-history flop.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    bcd_digit_counter u_units (
        .clk     (clk),
        .init    (init),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .digit   (units),
        .carry_c (units_carry_c)
    );

    bcd_digit_counter u_tens (
        .clk     (clk),
        .init    (init),
        .clr     (cnt_clr),
        .inc     (units_carry_c),
        .digit   (tens),
        .carry_c (tens_carry_c)
    );

    assign at_thr_c = (tens == THR_TENS) && (units == THR_UNITS);

    // count+1: the counter is incrementing on every MEASURE cycle, so its carries describe count+1.
    assign plus_units_c = bcd_next(units);
    assign plus_tens_c  = units_carry_c ? bcd_next(tens) : tens;

    // FSM state register.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter/latch control.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        load_meas = 1'b0;
        load_sat  = 1'b0;
        unique case (state_q)
            WAIT_FIRST: begin
                if (rise_c) begin
                    state_d = MEASURE;
                    cnt_clr = 1'b1;
                end
            end
            MEASURE: begin
                cnt_inc = 1'b1;
                if (rise_c) begin
                    load_meas = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (at_thr_c) begin
                    state_d = SATURATED;
                    cnt_inc = 1'b0;
                end
            end
            SATURATED: begin
                if (rise_c) begin
                    state_d  = MEASURE;
                    load_sat = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_FIRST;
            end
        endcase
    end

    // Result registers: latched on each reported edge, held otherwise.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            tens_q  <= '0;
            units_q <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= load_meas | load_sat;
            if (load_meas) begin
                tens_q  <= plus_tens_c;
                units_q <= plus_units_c;
                ovf     <= tens_carry_c;
            end else if (load_sat) begin
                tens_q  <= SAT_TENS;
                units_q <= SAT_UNITS;
                ovf     <= 1'b1;
            end
        end
    end

    assign {D_MSB, C_MSB, B_MSB, A_MSB} = tens_q;
    assign {D_LSB, C_LSB, B_LSB, A_LSB} = units_q;

endmodule

// File: tb/tb_period_meter_bcd.sv
// Self-checking bench for period_meter_bcd: period model plus literal spot checks.
module tb_period_meter_bcd;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MAX_BCD     = 99;
    localparam int          LAT         = SYNC_STAGES + 1;

    logic clk = 1'b0;
    logic init;
    logic sig_in;
    logic D_MSB, C_MSB, B_MSB, A_MSB;
    logic D_LSB, C_LSB, B_LSB, A_LSB;
    logic valid;
    logic ovf;
    logic [3:0] tens;
    logic [3:0] units;

    assign tens  = {D_MSB, C_MSB, B_MSB, A_MSB};
    assign units = {D_LSB, C_LSB, B_LSB, A_LSB};

    period_meter_bcd #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_BCD     (MAX_BCD)
    ) dut (
        .clk    (clk),
        .init   (init),
        .sig_in (sig_in),
        .D_MSB  (D_MSB),
        .C_MSB  (C_MSB),
        .B_MSB  (B_MSB),
        .A_MSB  (A_MSB),
        .D_LSB  (D_LSB),
        .C_LSB  (C_LSB),
        .B_LSB  (B_LSB),
        .A_LSB  (A_LSB),
        .valid  (valid),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    bit run         = 1'b0;

    // Model: report due at cycle -> encoded value (bit 8 = ovf).
    int         reports[int];
    bit         armed     = 1'b0;
    int         last_rise = 0;
    logic [3:0] exp_tens  = 4'd0;
    logic [3:0] exp_units = 4'd0;
    logic       exp_ovf   = 1'b0;
    logic       exp_valid;
    int         code;

    // A rising edge of sig_in launched on cycle cyc ends the period begun by the previous one.
    task automatic model_rise();
        int p;
        int v;
        if (armed) begin
            p = cyc - last_rise;
            v = (p > int'(MAX_BCD)) ? int'(MAX_BCD) : p;
            reports[cyc + LAT] = v + ((p > int'(MAX_BCD)) ? 256 : 0);
        end
        armed     = 1'b1;
        last_rise = cyc;
    endtask

    task automatic model_reset();
        reports.delete();
        armed     = 1'b0;
        exp_tens  = 4'd0;
        exp_units = 4'd0;
        exp_ovf   = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run && init) begin
            exp_valid = reports.exists(cyc);
            if (exp_valid) begin
                code      = reports[cyc];
                reports.delete(cyc);
                exp_tens  = 4'((code % 256) / 10);
                exp_units = 4'((code % 256) % 10);
                exp_ovf   = (code >= 256);
            end
            vectors++;
            if ({valid, tens, units, ovf} !== {exp_valid, exp_tens, exp_units, exp_ovf}) begin
                miscompares++;
                $display("FAIL model cycle %0d: got valid=%b bcd=%h%h ovf=%b, required valid=%b bcd=%h%h ovf=%b",
                         cyc, valid, tens, units, ovf, exp_valid, exp_tens, exp_units, exp_ovf);
            end
        end
    end

    // Hand-computed literal check of the presented result (valid must be low at these points).
    task automatic lit(input string name, input logic [3:0] t, input logic [3:0] u, input logic o);
        vectors++;
        if ({valid, tens, units, ovf} !== {1'b0, t, u, o}) begin
            miscompares++;
            $display("FAIL %s: got valid=%b bcd=%h%h ovf=%b, required valid=0 bcd=%h%h ovf=%b",
                     name, valid, tens, units, ovf, t, u, o);
        end
    endtask

    // One sig_in period of p clocks (p >= 2), starting with the rising edge; called on a negedge.
    task automatic emit(input int p);
        int hi;
        hi     = p / 2;
        sig_in = 1'b1;
        model_rise();
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (p - hi) @(negedge clk);
    endtask

    // Final edge that reports the preceding period, then settle.
    task automatic close();
        sig_in = 1'b1;
        model_rise();
        @(negedge clk);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Short active-low reset pulse between clock edges; called on a negedge.
    task automatic mid_reset();
        #1;
        init = 1'b0;
        model_reset();
        #1;
        lit("async_reset", 4'd0, 4'd0, 1'b0);
        #12;
        init = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        init   = 1'b1;
        sig_in = 1'b0;
        #1;
        init = 1'b0;
        #2;
        lit("reset_state", 4'd0, 4'd0, 1'b0);
        #9;
        init = 1'b1;
        @(negedge clk);
        run = 1'b1;

        // Divide-by-3 stream: first edge only arms.
        repeat (6) emit(3);
        close();
        lit("div3", 4'd0, 4'd3, 1'b0);

        repeat (5) emit(4);
        close();
        lit("period4", 4'd0, 4'd4, 1'b0);

        emit(37);
        close();
        lit("period37", 4'd3, 4'd7, 1'b0);

        emit(10);
        close();
        lit("period10", 4'd1, 4'd0, 1'b0);

        emit(150);
        emit(5);
        lit("period150", 4'd9, 4'd9, 1'b1);
        close();
        lit("period5_after_sat", 4'd0, 4'd5, 1'b0);

        emit(99);
        emit(4);
        lit("period99", 4'd9, 4'd9, 1'b0);
        emit(100);
        emit(4);
        lit("period100", 4'd9, 4'd9, 1'b1);

        // A one-clock period cannot present a 0-then-1 to the edge detector; the
        // shortest stream is sig_in toggling every clk, i.e. a 2-clock period.
        repeat (6) emit(2);
        close();
        lit("period2_toggle", 4'd0, 4'd2, 1'b0);

        emit(30);
        emit(20);
        mid_reset();
        emit(6);
        emit(6);
        close();
        lit("after_reset", 4'd0, 4'd6, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
